// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encodings and grant identifiers shared by the memory port arbiter.
package mem_port_arbiter_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_I_RD    = 3'd1;
    localparam logic [2:0] S_D_RD    = 3'd2;
    localparam logic [2:0] S_D_MERGE = 3'd3;
    localparam logic [2:0] S_D_WR    = 3'd4;
    localparam logic [2:0] S_ACK     = 3'd5;
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts stalled bus cycles and flags expiry after TIMEOUT_CYCLES of them.
module bus_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n || clear) cnt <= '0;
        else if (enable && cnt != '1) cnt <= cnt + TO_W'(1);
    // expired during the last allowed stall cycle so the abort lands on that edge
    assign expired = cnt >= TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and load/store ports,
// sequencing sub-word stores as read-merge-write and aborting stalled transfers.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_rmw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        wait_sig,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        bus_fault,
    output logic [31:0] fault_addr
);
    logic [2:0] state;
    logic grant, last_grant, op_we;
    logic pick_d, start, done, abort, expired, to_merge;
    assign pick_d   = d_req & (~i_req | last_grant != GRANT_D);
    assign start    = (state == S_IDLE && (i_req | d_req)) || state == S_D_MERGE;
    assign done     = m_valid & m_ready;
    assign abort    = m_valid & ~m_ready & expired;
    assign to_merge = state == S_D_RD && op_we;
    assign i_ack    = state == S_ACK && grant == GRANT_I;
    assign d_ack    = state == S_ACK && grant == GRANT_D;
    assign wait_sig = d_req & ~d_ack;

    bus_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_to (
        .clk(clk), .rst_n(rst_n), .clear(start), .enable(m_valid & ~m_ready), .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            grant <= GRANT_I;
            last_grant <= GRANT_I;
            op_we <= 1'b0;
            m_valid <= 1'b0;
            m_we <= 1'b0;
            m_addr <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            bus_fault <= 1'b0;
            fault_addr <= '0;
        end else begin
            bus_fault <= 1'b0;
            case (state)
                S_IDLE: if (i_req | d_req) begin
                    grant <= pick_d ? GRANT_D : GRANT_I;
                    op_we <= pick_d & d_we;
                    m_valid <= 1'b1;
                    m_we <= pick_d & d_we & ~d_rmw;
                    m_addr <= pick_d ? d_addr : i_addr;
                    m_wdata <= d_wdata;
                    state <= !pick_d ? S_I_RD : (d_we & ~d_rmw) ? S_D_WR : S_D_RD;
                end
                S_I_RD, S_D_RD, S_D_WR: if (done) begin
                    m_valid <= 1'b0;
                    m_we <= 1'b0;
                    if (state == S_I_RD) i_rdata <= m_rdata;
                    if (state == S_D_RD) d_rdata <= m_rdata;
                    if (!to_merge) last_grant <= grant;
                    state <= to_merge ? S_D_MERGE : S_ACK;
                end else if (abort) begin
                    m_valid <= 1'b0;
                    m_we <= 1'b0;
                    bus_fault <= 1'b1;
                    fault_addr <= m_addr;
                    if (grant == GRANT_I) i_rdata <= '0;
                    else d_rdata <= '0;
                    last_grant <= grant;
                    state <= S_ACK;
                end
                S_D_MERGE: begin
                    m_valid <= 1'b1;
                    m_we <= 1'b1;
                    m_wdata <= d_wdata;
                    state <= S_D_WR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench with a transaction-level model of
// arbitration order, latency and expected bus traffic.
module tb_mem_port_arbiter;
    localparam int TO = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_rmw = 1'b0, m_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, fault_addr;
    logic i_ack, d_ack, wait_sig, m_valid, m_we, bus_fault;

    typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} xfer_t;
    xfer_t log_q[$];
    int waits_cfg = 0, wc = 0;
    bit stall = 1'b0;
    bit lg_d = 1'b0;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_rmw(d_rmw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .wait_sig(wait_sig), .m_valid(m_valid), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .bus_fault(bus_fault), .fault_addr(fault_addr)
    );

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h203) return 32'h11223344;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] rd, input logic [7:0] b);
        return {rd[31:8], b};
    endfunction

    // Bus slave: fixed wait count per transfer, random noise on m_ready while idle.
    always @(negedge clk) begin
        xfer_t x;
        if (m_valid) begin
            if (stall || wc < waits_cfg) begin
                m_ready = 1'b0;
                m_rdata = $urandom;
                wc++;
            end else begin
                m_ready = 1'b1;
                m_rdata = rd_of(m_addr);
                x.addr = m_addr; x.we = m_we; x.wdata = m_wdata;
                log_q.push_back(x);
                wc = 0;
            end
        end else begin
            m_ready = 1'($urandom_range(0, 1));
            m_rdata = $urandom;
            wc = 0;
        end
    end

    task automatic do_txn(input bit ui, input bit ud, input bit we, input bit rmw,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw, input int w);
        bit d_first, got_i, got_d, rmw_eff, is_d;
        int li, ld, ei, ed, cyc;
        xfer_t e;
        xfer_t exp_q[$];
        rmw_eff = we & rmw;
        li = 2 + w;
        ld = rmw_eff ? 4 + 2 * w : 2 + w;
        d_first = ud && (!ui || !lg_d);
        if (ui && ud) begin
            ed = d_first ? ld : li + 1 + ld;
            ei = d_first ? ld + 1 + li : li;
        end else begin
            ei = ui ? li : -1;
            ed = ud ? ld : -1;
        end
        for (int p = 0; p < 2; p++) begin
            is_d = (p == 0) ? d_first : !d_first;
            if (is_d ? !ud : !ui) continue;
            e.addr = is_d ? da : ia; e.we = 1'b0; e.wdata = '0;
            if (!is_d || !we || rmw) exp_q.push_back(e);
            if (is_d && we) begin
                e.we = 1'b1;
                e.wdata = rmw ? merge(rd_of(da), dw[7:0]) : dw;
                exp_q.push_back(e);
            end
        end
        lg_d = (ui && ud) ? !d_first : ud;
        waits_cfg = w;
        stall = 1'b0;
        log_q.delete();
        @(posedge clk); #1;
        i_req = ui; i_addr = ia; d_req = ud; d_we = we; d_rmw = rmw; d_addr = da; d_wdata = dw;
        cyc = 0; got_i = !ui; got_d = !ud;
        while (!(got_i && got_d) && cyc < 100) begin
            @(negedge clk);
            if (ud && rmw_eff && !got_d) d_wdata = merge(d_rdata, dw[7:0]);
            checks++; if (i_ack !== (cyc == ei)) $display("FAIL i_ack cyc=%0d got=%b exp=%b", cyc, i_ack, cyc == ei); else passed++;
            checks++; if (d_ack !== (cyc == ed)) $display("FAIL d_ack cyc=%0d got=%b exp=%b", cyc, d_ack, cyc == ed); else passed++;
            checks++; if (wait_sig !== (ud && !got_d && cyc != ed)) $display("FAIL wait_sig cyc=%0d got=%b", cyc, wait_sig); else passed++;
            checks++; if (bus_fault !== 1'b0) $display("FAIL bus_fault_idle cyc=%0d got=%b exp=0", cyc, bus_fault); else passed++;
            if (cyc == ei) begin
                checks++; if (i_rdata !== rd_of(ia)) $display("FAIL i_rdata got=%h exp=%h", i_rdata, rd_of(ia)); else passed++;
                got_i = 1'b1; i_req = 1'b0;
            end
            if (cyc == ed) begin
                if (!we || rmw) begin
                    checks++; if (d_rdata !== rd_of(da)) $display("FAIL d_rdata got=%h exp=%h", d_rdata, rd_of(da)); else passed++;
                end
                got_d = 1'b1; d_req = 1'b0;
            end
            cyc++;
        end
        checks++; if (cyc >= 100) $display("FAIL txn_timeout got=%0d cycles exp<100", cyc); else passed++;
        checks++; if (log_q.size() != exp_q.size()) $display("FAIL bus_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else passed++;
        for (int n = 0; n < exp_q.size() && n < log_q.size(); n++) begin
            checks++;
            if (log_q[n].addr !== exp_q[n].addr || log_q[n].we !== exp_q[n].we || (exp_q[n].we && log_q[n].wdata !== exp_q[n].wdata))
                $display("FAIL bus_xfer[%0d] got=%h/%b/%h exp=%h/%b/%h", n, log_q[n].addr, log_q[n].we, log_q[n].wdata, exp_q[n].addr, exp_q[n].we, exp_q[n].wdata);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got=%b exp=0", m_valid); else passed++;
        checks++; if ({i_ack, d_ack, bus_fault, wait_sig, m_we} !== 5'b0) $display("FAIL rst_flags got=%b exp=0", {i_ack, d_ack, bus_fault, wait_sig, m_we}); else passed++;
        checks++; if ({i_rdata, d_rdata, fault_addr} !== 96'b0) $display("FAIL rst_regs got=%h exp=0", {i_rdata, d_rdata, fault_addr}); else passed++;
        checks++; if ({m_addr, m_wdata} !== 64'b0) $display("FAIL rst_bus got=%h exp=0", {m_addr, m_wdata}); else passed++;
        rst_n = 1'b1;
        lg_d = 1'b0;
    endtask

    task automatic test_arbitration;
        do_txn(1, 1, 0, 0, 32'h1000, 32'h2000, 0, 0);
        do_txn(1, 1, 0, 0, 32'h1004, 32'h2004, 0, 1);
        do_txn(0, 1, 0, 0, 0, 32'h2008, 0, 0);
        do_txn(1, 1, 1, 0, 32'h1008, 32'h200C, 32'hCAFEF00D, 0);
    endtask

    task automatic test_load;
        do_txn(0, 1, 0, 0, 0, 32'h100, 0, 0);
    endtask

    task automatic test_rmw;
        do_txn(0, 1, 1, 1, 0, 32'h203, 32'h55, 0);
    endtask

    task automatic test_timeout;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 32'h300 + 32'(k * 4);
            stall = 1'b1;
            log_q.delete();
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 1'(k); d_rmw = 1'(k); d_addr = a; d_wdata = 32'h77;
            for (int cyc = 0; cyc <= TO + 1; cyc++) begin
                @(negedge clk);
                checks++; if (m_valid !== (cyc >= 1 && cyc <= TO)) $display("FAIL to_m_valid cyc=%0d got=%b", cyc, m_valid); else passed++;
                checks++; if (d_ack !== (cyc == TO + 1)) $display("FAIL to_d_ack cyc=%0d got=%b", cyc, d_ack); else passed++;
                checks++; if (bus_fault !== (cyc == TO + 1)) $display("FAIL to_bus_fault cyc=%0d got=%b", cyc, bus_fault); else passed++;
                if (cyc == TO + 1) begin
                    checks++; if (fault_addr !== a) $display("FAIL to_fault_addr got=%h exp=%h", fault_addr, a); else passed++;
                    checks++; if (d_rdata !== 32'h0) $display("FAIL to_d_rdata got=%h exp=0", d_rdata); else passed++;
                    d_req = 1'b0;
                end
            end
            @(negedge clk);
            checks++; if ({bus_fault, m_valid} !== 2'b00) $display("FAIL to_after got=%b exp=00", {bus_fault, m_valid}); else passed++;
            checks++; if (fault_addr !== a) $display("FAIL to_fault_hold got=%h exp=%h", fault_addr, a); else passed++;
            checks++; if (log_q.size() != 0) $display("FAIL to_no_xfer got=%0d exp=0", log_q.size()); else passed++;
        end
        stall = 1'b0;
        lg_d = 1'b1;
    endtask

    task automatic test_random;
        int r;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 2);
            do_txn(r != 1, r != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_midtxn;
        stall = 1'b1;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_rmw = 1'b0; d_addr = 32'h400; d_wdata = 32'hA5A5A5A5;
        repeat (2) @(negedge clk);
        checks++; if ({m_valid, m_we, m_addr} !== {2'b11, 32'h400}) $display("FAIL mid_wr got=%b%b %h exp=11 400", m_valid, m_we, m_addr); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) $display("FAIL mid_rst_m_valid got=%b exp=0", m_valid); else passed++;
        checks++; if ({d_ack, i_ack} !== 2'b00) $display("FAIL mid_rst_ack got=%b exp=00", {d_ack, i_ack}); else passed++;
        checks++; if (wait_sig !== 1'b1) $display("FAIL mid_rst_wait got=%b exp=1", wait_sig); else passed++;
        @(negedge clk);
        checks++; if (d_ack !== 1'b0) $display("FAIL mid_rst_noack got=%b exp=0", d_ack); else passed++;
        d_req = 1'b0; stall = 1'b0; rst_n = 1'b1;
        lg_d = 1'b0;
        do_txn(1, 1, 0, 0, 32'h500, 32'h600, 0, 0);
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_load();
        test_rmw();
        test_timeout();
        test_random();
        test_reset_midtxn();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
